key_round_ctrl: RTL and testbench

Round controller for the keypad reaction game: it synchronises and debounces the raw keypad scanner output and generates the pseudo-random target key for each round. It tracks one press per round and produces `key`, `key_random`, `pressed` and the 26-bit press-age counter `cnt`. The voice selector directly downstream consumes these to choose the feedback tone. A saturating hit score is kept for the display path.

---
 rtl/key_round_ctrl.sv | 104 ++++++++++
 tb/tb_key_round_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/key_round_ctrl.sv
// key_round_ctrl: debounced keypad press tracking, LFSR round target and hit score
module key_round_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_hit,
  input  logic [3:0]  key_raw,
  input  logic        start,
  output logic [3:0]  key,
  output logic [3:0]  key_random,
  output logic        pressed,
  output logic [25:0] cnt,
  output logic [7:0]  score
);
  typedef enum logic [1:0] {IDLE, ARMED, HELD} state_t;

  localparam logic [19:0] DB_MAX = 20'(DEBOUNCE_CYCLES);

  logic        hit_s1_q, hit_s2_q;
  logic [3:0]  raw_s1_q, raw_s2_q;
  logic        stable_q, stable_d, stable_prev_q;
  logic [19:0] db_q, db_d;
  logic [15:0] lfsr_q, lfsr_d;
  state_t      state_q, state_d;
  logic [3:0]  key_q, key_d, key_random_q, key_random_d;
  logic        pressed_q, pressed_d;
  logic [25:0] cnt_q, cnt_d;
  logic [7:0]  score_q, score_d;
  logic        rise, fall;

  // debouncer: count consecutive disagreeing cycles, accept the level once the count hits the limit
  always_comb begin
    db_d     = (hit_s2_q == stable_q || db_q == DB_MAX) ? '0 : db_q + 20'd1;
    stable_d = (hit_s2_q != stable_q && db_q == DB_MAX) ? hit_s2_q : stable_q;
    lfsr_d   = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ 16'hB400) : {1'b0, lfsr_q[15:1]};
    rise     = stable_q & ~stable_prev_q;
    fall     = ~stable_q & stable_prev_q;
  end

  // round FSM next state; start overrides any stable edge in the same cycle
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    key_random_d = key_random_q;
    score_d      = score_q;
    if (start) begin
      state_d      = ARMED;
      key_random_d = lfsr_q[3:0];
      score_d      = '0;
    end else if (state_q == ARMED && rise) begin
      state_d = HELD;
      key_d   = raw_s2_q;
      score_d = (raw_s2_q == key_random_q && score_q != 8'hFF) ? score_q + 8'd1 : score_q;
    end else if (state_q == HELD && fall) begin
      state_d      = ARMED;
      key_random_d = lfsr_q[3:0];
    end
    pressed_d = (state_d == HELD);
    cnt_d     = (state_q == HELD && state_d == HELD) ? ((&cnt_q) ? cnt_q : cnt_q + 26'd1) : '0;
  end

  // all state registers, including the two-stage input synchronisers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_s1_q      <= 1'b0;
      hit_s2_q      <= 1'b0;
      raw_s1_q      <= '0;
      raw_s2_q      <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      db_q          <= '0;
      lfsr_q        <= LFSR_SEED;
      state_q       <= IDLE;
      key_q         <= '0;
      key_random_q  <= '0;
      pressed_q     <= 1'b0;
      cnt_q         <= '0;
      score_q       <= '0;
    end else begin
      hit_s1_q      <= key_hit;
      hit_s2_q      <= hit_s1_q;
      raw_s1_q      <= key_raw;
      raw_s2_q      <= raw_s1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      db_q          <= db_d;
      lfsr_q        <= lfsr_d;
      state_q       <= state_d;
      key_q         <= key_d;
      key_random_q  <= key_random_d;
      pressed_q     <= pressed_d;
      cnt_q         <= cnt_d;
      score_q       <= score_d;
    end
  end

  assign key        = key_q;
  assign key_random = key_random_q;
  assign pressed    = pressed_q;
  assign cnt        = cnt_q;
  assign score      = score_q;
endmodule

// File: tb/tb_key_round_ctrl.sv
// tb_key_round_ctrl: table-driven presses with a press scoreboard and hand-written corner sequences
module tb_key_round_ctrl;
  localparam int          D    = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0, rst_n = 1'b0, key_hit = 1'b0, start = 1'b0;
  logic [3:0]  key_raw = 4'h0;
  logic [3:0]  key, key_random;
  logic        pressed;
  logic [25:0] cnt;
  logic [7:0]  score;

  always #5 clk = ~clk;

  key_round_ctrl #(.DEBOUNCE_CYCLES(D), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .key_hit(key_hit), .key_raw(key_raw), .start(start),
    .key(key), .key_random(key_random), .pressed(pressed), .cnt(cnt), .score(score)
  );

  typedef struct {logic [3:0] key; logic [7:0] score; int e0;} exp_t;
  typedef struct {int hold; logic [3:0] code; bit rel; bit acc;} vec_t;

  exp_t        sb[$];
  exp_t        e;
  vec_t        vt[7];
  int          n_tot = 0, n_pass = 0, cyc = 0;
  logic [15:0] m_lfsr = SEED, lfsr_edge = SEED;
  logic [3:0]  exp_key = 4'h0, exp_target = 4'h0, kr_hold = 4'h0;
  logic [7:0]  exp_score = 8'h0;
  logic        prev_p = 1'b0, skip_cnt = 1'b0;
  logic [25:0] prev_cnt = '0;

  function automatic logic [15:0] step(input logic [15:0] x);
    return x[0] ? ({1'b0, x[15:1]} ^ 16'hB400) : {1'b0, x[15:1]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // lfsr_edge holds the LFSR value the DUT samples at the most recent edge
  always @(posedge clk) begin
    if (!rst_n) begin
      m_lfsr    = SEED;
      lfsr_edge = SEED;
    end else begin
      lfsr_edge = m_lfsr;
      m_lfsr    = step(m_lfsr);
    end
    cyc = cyc + 1;
  end

  // press monitor: pops the scoreboard on each accepted press and follows cnt while held
  always @(negedge clk) begin
    if (!rst_n) prev_p = 1'b0;
    else begin
      if (pressed && !prev_p) begin
        if (sb.size() == 0) begin
          n_tot++;
          $display("FAIL unexpected_press: got pressed=1, required no press");
        end else begin
          e = sb.pop_front();
          chk("press_key", 32'(key), 32'(e.key));
          chk("press_score", 32'(score), 32'(e.score));
          chk("press_latency", cyc - e.e0, D + 3);
        end
        chk("cnt_first", 32'(cnt), 32'd0);
        kr_hold = key_random;
      end else if (pressed) begin
        if (skip_cnt) skip_cnt = 1'b0;
        else chk("cnt_step", 32'(cnt), 32'((&prev_cnt) ? prev_cnt : prev_cnt + 26'd1));
        chk("kr_stable_held", 32'(key_random), 32'(kr_hold));
      end
      prev_p   = pressed;
      prev_cnt = cnt;
    end
  end

  task automatic hit_on(input logic [3:0] c, input bit acc);
    @(negedge clk);
    key_raw = c;
    key_hit = 1'b1;
    if (acc) begin
      exp_score = (c == exp_target && exp_score != 8'hFF) ? exp_score + 8'd1 : exp_score;
      exp_key   = c;
      sb.push_back('{c, exp_score, cyc + 1});
    end
  endtask

  task automatic hit_off(input bit acc);
    int r0;
    @(negedge clk);
    key_hit = 1'b0;
    r0 = cyc + 1;
    if (acc) begin
      repeat (D + 3) @(negedge clk);
      chk("held_before_release", 32'(pressed), 32'd1);
      @(negedge clk);
      chk("release_latency", 32'(pressed), 32'd0);
      chk("cnt_after_release", 32'(cnt), 32'd0);
      chk("round_target", 32'(key_random), 32'(lfsr_edge[3:0]));
      exp_target = lfsr_edge[3:0];
    end else begin
      repeat (12) @(negedge clk);
      chk("reject_pressed", 32'(pressed), 32'd0);
      chk("reject_key", 32'(key), 32'(exp_key));
      chk("reject_score", 32'(score), 32'(exp_score));
      chk("reject_target", 32'(key_random), 32'(exp_target));
    end
  endtask

  task automatic press(input int h, input logic [3:0] c, input bit acc);
    hit_on(c, acc);
    repeat (h - 1) @(negedge clk);
    hit_off(acc);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_target = lfsr_edge[3:0];
    exp_score  = 8'h0;
    chk("start_target", 32'(key_random), 32'(exp_target));
    chk("start_score", 32'(score), 32'd0);
    chk("start_pressed", 32'(pressed), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_key"}, 32'(key), 32'd0);
    chk({tag, "_key_random"}, 32'(key_random), 32'd0);
    chk({tag, "_pressed"}, 32'(pressed), 32'd0);
    chk({tag, "_cnt"}, 32'(cnt), 32'd0);
    chk({tag, "_score"}, 32'(score), 32'd0);
  endtask

  initial begin
    vt = '{'{20, 4'h5, 1'b0, 1'b1}, '{3, 4'h5, 1'b0, 1'b0}, '{1, 4'h9, 1'b0, 1'b0},
           '{8, 4'h0, 1'b1, 1'b1}, '{8, 4'h1, 1'b1, 1'b1}, '{5, 4'h0, 1'b1, 1'b1},
           '{12, 4'h3, 1'b1, 1'b1}};
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    press(8, 4'h5, 1'b0);
    do_start();
    foreach (vt[i]) press(vt[i].hold, vt[i].rel ? (exp_target ^ vt[i].code) : vt[i].code, vt[i].acc);
    hit_on(exp_target, 1'b1);
    repeat (11) @(negedge clk);
    @(posedge clk);
    #1 skip_cnt = 1'b1;
    force dut.cnt_q = 26'h3FFFFFD;
    #1 release dut.cnt_q;
    repeat (4) @(negedge clk);
    chk("cnt_saturate", 32'(cnt), 32'h3FFFFFF);
    repeat (3) @(negedge clk);
    chk("cnt_hold_max", 32'(cnt), 32'h3FFFFFF);
    hit_off(1'b1);
    hit_on(exp_target, 1'b1);
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_pressed", 32'(pressed), 32'd0);
    chk("abort_cnt", 32'(cnt), 32'd0);
    chk("abort_score", 32'(score), 32'd0);
    chk("abort_target", 32'(key_random), 32'(lfsr_edge[3:0]));
    exp_target = lfsr_edge[3:0];
    exp_score  = 8'h0;
    repeat (20) @(negedge clk);
    chk("abort_no_reaccept", 32'(pressed), 32'd0);
    hit_off(1'b0);
    press(8, exp_target, 1'b1);
    hit_on(exp_target, 1'b1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    key_hit = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_key = 4'h0;
    exp_score = 8'h0;
    exp_target = 4'h0;
    repeat (3) @(negedge clk);
    do_start();
    for (int k = 0; k < 256; k++) press(5, exp_target, 1'b1);
    chk("score_saturate", 32'(score), 32'd255);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
